seg_scan_decoder: RTL and testbench
===================================

// Module: seg_scan_decoder
// PURPOSE
// - Reverse of the hex-to-7-segment encoder: monitors a multiplexed, active-low 7-segment drive bus
//   (segment cathodes + digit anodes) and reconstructs the hex nibble and decimal point of every digit.
// - Used as an on-chip display readback/self-check and as a bench-side display monitor.
// - Captures a digit only after its drive pattern has been stable for a qualification window.
// PARAMETERS
// - DIGITS       4     number of multiplexed digits (>=2); IW = $clog2(DIGITS)
// - STABLE_CYC   4     consecutive unchanged samples required before capture (>=2)
// - TIMEOUT_CYC  1024  refresh timeout in cycles; used only with SEG_DEC_TIMEOUT_EN
// PORTS
// - clk      in   1          system clock, rising edge
// - rst_n    in   1          synchronous, active-low reset
// - seg_n    in   8          segment drive, active-low; [7]=dp, [6:0]=g..a
// - an_n     in   DIGITS     digit enables, active-low; exactly one low = valid scan slot
// - hex_out  out  4*DIGITS   decoded nibble per digit; digit i at [4i+3:4i]
// - dp_out   out  DIGITS     1 = decimal point lit on digit i (seg_n[7]==0)
// - valid    out  DIGITS     1 = digit i holds a decoded legal pattern
// - upd_stb  out  1          one-cycle pulse: a digit register was written
// - upd_idx  out  IW         index of the digit written; held between pulses
// - err_stb  out  1          one-cycle pulse: illegal pattern captured on a single enabled digit
// BEHAVIOUR
// - Reset: hex_out=0, dp_out=0, valid=0, upd_stb=0, upd_idx=0, err_stb=0, FSM=IDLE, counters=0.
//   Reset asserted mid-qualification aborts the capture; no pulse is emitted on or after that edge.
// - Input path: {an_n,seg_n} passes through 2 flop stages (s1,s2); s2 is compared against the previous s2.
// - Stability counter cnt: s2 != prev -> cnt=0; else cnt increments, saturating at STABLE_CYC.
// - FSM:
//   - IDLE: any change -> QUAL.
//   - QUAL: change -> stay QUAL (cnt=0); cnt reaches STABLE_CYC -> CAPTURE.
//   - CAPTURE (1 cycle): evaluate the stable sample -> HELD.
//   - HELD: no recapture while the sample is unchanged; change -> QUAL.
// - Latency: inputs applied before edge k and held -> upd_stb/err_stb high in the cycle after
//   edge k+STABLE_CYC+2; hex_out/dp_out/valid update on that same edge.
// - Decode table, seg_n[6:0] -> nibble:
//   0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=18 A=08 b=03 c=27 d=21 E=06 F=0E.
// - CAPTURE rules (i = index of the single low bit in an_n):
//   - an_n not one-hot-low (all high or >=2 low) -> no write, no pulse.
//   - seg_n[6:0]==7F (blank) -> valid[i]=0, hex/dp unchanged, no pulse.
//   - table hit -> hex_out[i]=nibble, dp_out[i]=~seg_n[7], valid[i]=1, upd_idx=i, upd_stb=1.
//   - otherwise -> err_stb=1, valid[i]=0, hex/dp unchanged.
// - upd_stb and err_stb are mutually exclusive; each asserts at most once per stable window.
// - Digits other than i are never modified by a capture.
// CONFIGURATION
// - SEG_DEC_TIMEOUT_EN defined: a per-digit age counter, width $clog2(TIMEOUT_CYC+1),
//   clears on each upd_stb for that digit and increments otherwise.
//   - Reaching TIMEOUT_CYC clears valid[i], leaves hex/dp unchanged, and emits no pulse.
//   - Counters clear on reset.
// - SEG_DEC_TIMEOUT_EN undefined: no age counters; valid[i] changes only via capture or reset.
// TESTING (DIGITS=4, STABLE_CYC=4)
// - an_n=1110, seg_n=A4 held 10 cycles -> 6 edges later hex_out[3:0]=2, dp_out[0]=0, valid=0001,
//   upd_idx=0, exactly one upd_stb.
// - an_n=1011, seg_n=12 held -> hex_out[11:8]=5, dp_out[2]=1, valid[2]=1, other digits unchanged.
// - seg_n toggles A4/B0 every 3 cycles on an_n=1110 -> no upd_stb, no err_stb; outputs unchanged.
// - an_n=1101, seg_n=FE held -> one err_stb, valid[1]=0, hex_out[7:4] keeps prior value;
//   then an_n=1100 held -> no pulses.
// - Full scan 0..3 with digits 1,2,3,4, each held 8 cycles -> hex_out=16'h4321, four upd_stb,
//   upd_idx=0,1,2,3 in order.
// - rst_n low at cnt=2 of a capture -> all outputs 0, no pulse.
//   With SEG_DEC_TIMEOUT_EN: digit 0 captured, then an_n=1111 for 1024 cycles -> valid[0]=0.

Source files
------------

// File: rtl/seg_scan_if.sv
// seg_scan_if: multiplexed active-low 7-segment drive bus together with the
// per-digit readback produced by seg_scan_decoder.
interface seg_scan_if #(
  parameter int DIGITS = 4
);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [7:0]          seg_n;
  logic [DIGITS-1:0]   an_n;
  logic [4*DIGITS-1:0] hex_out;
  logic [DIGITS-1:0]   dp_out;
  logic [DIGITS-1:0]   valid;
  logic                upd_stb;
  logic [IW-1:0]       upd_idx;
  logic                err_stb;

  modport master (
    output seg_n, an_n,
    input  hex_out, dp_out, valid, upd_stb, upd_idx, err_stb
  );

  modport slave (
    input  seg_n, an_n,
    output hex_out, dp_out, valid, upd_stb, upd_idx, err_stb
  );
endinterface

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: rebuilds hex nibbles and decimal points from a multiplexed 7-segment bus.
// Optional per-digit refresh timeout is enabled by defining SEG_DEC_TIMEOUT_EN.
module seg_scan_decoder #(
  parameter int DIGITS      = 4,
  parameter int STABLE_CYC  = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input logic       clk,
  input logic       rst_n,
  seg_scan_if.slave bus
);
  localparam int IW = $clog2(DIGITS);
  localparam int SW = DIGITS + 8;
  localparam int CW = $clog2(STABLE_CYC + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    QUAL    = 2'd1,
    CAPTURE = 2'd2,
    HELD    = 2'd3
  } state_t;

  // Segment pattern -> {hit, nibble}
  function automatic logic [4:0] seg_decode(input logic [6:0] pat);
    case (pat)
      7'h40:   seg_decode = {1'b1, 4'h0};
      7'h79:   seg_decode = {1'b1, 4'h1};
      7'h24:   seg_decode = {1'b1, 4'h2};
      7'h30:   seg_decode = {1'b1, 4'h3};
      7'h19:   seg_decode = {1'b1, 4'h4};
      7'h12:   seg_decode = {1'b1, 4'h5};
      7'h02:   seg_decode = {1'b1, 4'h6};
      7'h78:   seg_decode = {1'b1, 4'h7};
      7'h00:   seg_decode = {1'b1, 4'h8};
      7'h18:   seg_decode = {1'b1, 4'h9};
      7'h08:   seg_decode = {1'b1, 4'hA};
      7'h03:   seg_decode = {1'b1, 4'hB};
      7'h27:   seg_decode = {1'b1, 4'hC};
      7'h21:   seg_decode = {1'b1, 4'hD};
      7'h06:   seg_decode = {1'b1, 4'hE};
      7'h0E:   seg_decode = {1'b1, 4'hF};
      default: seg_decode = {1'b0, 4'h0};
    endcase
  endfunction

  // Active-high select -> {exactly_one, index of the set bit}
  function automatic logic [IW:0] onehot_idx(input logic [DIGITS-1:0] sel);
    int            n;
    logic [IW-1:0] idx;
    n   = 0;
    idx = {IW{1'b0}};
    for (int j = 0; j < DIGITS; j++) begin
      n   = n + int'(sel[j]);
      idx = sel[j] ? IW'(j) : idx;
    end
    onehot_idx = {(n == 1), idx};
  endfunction

  logic [SW-1:0]       s1_r, s2_r, prev_r;
  logic [CW-1:0]       cnt_r;
  state_t              state_r, state_s;
  logic                chg_s, qual_done_s;
  logic                sel_ok_s, wr_s, clr_s, err_s;
  logic [IW-1:0]       sel_idx_s;
  logic [4:0]          dec_s;
  logic [DIGITS-1:0]   age_exp_s;
  logic [4*DIGITS-1:0] hex_out_r;
  logic [DIGITS-1:0]   dp_out_r, valid_r;
  logic                upd_stb_r, err_stb_r;
  logic [IW-1:0]       upd_idx_r;

  assign chg_s       = (s2_r != prev_r);
  assign qual_done_s = (state_r == QUAL) && !chg_s && (cnt_r == CW'(STABLE_CYC - 1));

  // Two-flop input stage plus the previous s2 sample for change detection
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_r   <= {SW{1'b1}};
      s2_r   <= {SW{1'b1}};
      prev_r <= {SW{1'b1}};
    end else begin
      s1_r   <= {bus.an_n, bus.seg_n};
      s2_r   <= s1_r;
      prev_r <= s2_r;
    end
  end

  // Stability counter, saturating at STABLE_CYC
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r <= {CW{1'b0}};
    end else if (chg_s) begin
      cnt_r <= {CW{1'b0}};
    end else if (cnt_r != CW'(STABLE_CYC)) begin
      cnt_r <= cnt_r + 1'b1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    state_s = chg_s ? QUAL : IDLE;
      QUAL:    state_s = qual_done_s ? CAPTURE : QUAL;
      CAPTURE: state_s = chg_s ? QUAL : HELD;
      HELD:    state_s = chg_s ? QUAL : HELD;
      default: state_s = IDLE;
    endcase
  end

  // Capture evaluation; it lands on the edge that enters CAPTURE so the
  // stable sample is judged exactly when qualification completes.
  always_comb begin
    {sel_ok_s, sel_idx_s} = onehot_idx(~s2_r[SW-1:8]);
    dec_s = seg_decode(s2_r[6:0]);
    wr_s  = 1'b0;
    clr_s = 1'b0;
    err_s = 1'b0;
    if (qual_done_s && sel_ok_s) begin
      if (s2_r[6:0] == 7'h7F) begin
        clr_s = 1'b1;
      end else if (dec_s[4]) begin
        wr_s = 1'b1;
      end else begin
        err_s = 1'b1;
        clr_s = 1'b1;
      end
    end else begin
      wr_s = 1'b0;
    end
  end

`ifdef SEG_DEC_TIMEOUT_EN
  localparam int AW = $clog2(TIMEOUT_CYC + 1);
  logic [AW-1:0] age_r [DIGITS];

  // Per-digit refresh age; cleared by a successful write, saturates at TIMEOUT_CYC
  always_ff @(posedge clk) begin
    for (int i = 0; i < DIGITS; i++) begin
      if (!rst_n) begin
        age_r[i] <= {AW{1'b0}};
      end else if (wr_s && (sel_idx_s == IW'(i))) begin
        age_r[i] <= {AW{1'b0}};
      end else if (age_r[i] != AW'(TIMEOUT_CYC)) begin
        age_r[i] <= age_r[i] + 1'b1;
      end else begin
        age_r[i] <= age_r[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < DIGITS; i++) begin
      age_exp_s[i] = (age_r[i] == AW'(TIMEOUT_CYC - 1));
    end
  end
`else
  assign age_exp_s = {DIGITS{1'b0}};
`endif

  // Registered digit store and status pulses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hex_out_r <= {(4*DIGITS){1'b0}};
      dp_out_r  <= {DIGITS{1'b0}};
      valid_r   <= {DIGITS{1'b0}};
      upd_stb_r <= 1'b0;
      err_stb_r <= 1'b0;
      upd_idx_r <= {IW{1'b0}};
    end else begin
      upd_stb_r <= wr_s;
      err_stb_r <= err_s;
      upd_idx_r <= wr_s ? sel_idx_s : upd_idx_r;
      for (int i = 0; i < DIGITS; i++) begin
        if (wr_s && (sel_idx_s == IW'(i))) begin
          hex_out_r[4*i +: 4] <= dec_s[3:0];
          dp_out_r[i]         <= ~s2_r[7];
          valid_r[i]          <= 1'b1;
        end else if ((clr_s && (sel_idx_s == IW'(i))) || age_exp_s[i]) begin
          valid_r[i] <= 1'b0;
        end else begin
          valid_r[i] <= valid_r[i];
        end
      end
    end
  end

  assign bus.hex_out = hex_out_r;
  assign bus.dp_out  = dp_out_r;
  assign bus.valid   = valid_r;
  assign bus.upd_stb = upd_stb_r;
  assign bus.err_stb = err_stb_r;
  assign bus.upd_idx = upd_idx_r;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb_seg_scan_decoder: directed plus random scan patterns; expected capture events are
// queued by a pattern-level reference model and checked by an independent monitor.
module tb_seg_scan_decoder;
  localparam int DIGITS  = 4;
  localparam int STABLE  = 4;
  localparam int TIMEOUT = 1024;
`ifdef SEG_DEC_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  seg_scan_if #(.DIGITS(DIGITS)) bus ();

  seg_scan_decoder #(
    .DIGITS(DIGITS), .STABLE_CYC(STABLE), .TIMEOUT_CYC(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Forward encoder table: nibble -> active-low segments g..a
  logic [6:0] enc [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h18, 7'h08, 7'h03, 7'h27, 7'h21, 7'h06, 7'h0E};

  logic [3:0]  mhex   [DIGITS];
  logic        mdp    [DIGITS];
  logic        mvalid [DIGITS];
  int          mupd   [DIGITS];
  logic [1:0]  midx;
  logic [11:0] prev_pat;

  typedef struct {
    logic       err;
    logic [1:0] idx;
    logic [15:0] hex;
    logic [3:0] dp;
    logic [3:0] valid;
    int         at;
  } exp_t;
  exp_t q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] mhex_vec();
    logic [15:0] r;
    for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = mhex[i];
    return r;
  endfunction

  function automatic logic [3:0] mdp_vec();
    logic [3:0] r;
    for (int i = 0; i < DIGITS; i++) r[i] = mdp[i];
    return r;
  endfunction

  // A digit stays valid until TIMEOUT cycles have passed since its last write
  function automatic logic [3:0] eff_valid(input int t);
    logic [3:0] r;
    for (int i = 0; i < DIGITS; i++) r[i] = mvalid[i] && (!TO_EN || (t - mupd[i] < TIMEOUT));
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DIGITS; i++) begin
      mhex[i] = 4'h0; mdp[i] = 1'b0; mvalid[i] = 1'b0; mupd[i] = 0;
    end
    midx     = 2'd0;
    prev_pat = 12'hFFF;
  endtask

  // Judge one stable pattern that is captured at edge t
  task automatic model_capture(input logic [3:0] an, input logic [7:0] seg, input int t);
    int   n   = 0;
    int   i   = 0;
    int   nib = -1;
    exp_t e;
    for (int d = 0; d < DIGITS; d++) if (!an[d]) begin n++; i = d; end
    if (n != 1) return;
    if (seg[6:0] == 7'h7F) begin mvalid[i] = 1'b0; return; end
    for (int v = 0; v < 16; v++) if (enc[v] == seg[6:0]) nib = v;
    if (nib >= 0) begin
      mhex[i] = 4'(nib); mdp[i] = ~seg[7]; mvalid[i] = 1'b1; mupd[i] = t; midx = 2'(i);
    end else begin
      mvalid[i] = 1'b0;
    end
    e.err = (nib < 0); e.idx = midx; e.hex = mhex_vec(); e.dp = mdp_vec();
    e.valid = eff_valid(t); e.at = t;
    q.push_back(e);
  endtask

  // Drive a pattern for h cycles; a pattern held STABLE+1 cycles or more is captured
  task automatic apply(input logic [3:0] an, input logic [7:0] seg, input int h);
    bus.an_n  = an;
    bus.seg_n = seg;
    if (({an, seg} != prev_pat) && (h >= STABLE + 1)) model_capture(an, seg, cyc + STABLE + 3);
    prev_pat = {an, seg};
    repeat (h) @(negedge clk);
  endtask

  task automatic check_state(input string tag);
    check({tag, "_hex"},   bus.hex_out, mhex_vec());
    check({tag, "_dp"},    bus.dp_out,  mdp_vec());
    check({tag, "_valid"}, bus.valid,   eff_valid(cyc));
  endtask

  // Monitor: every pulse must match the oldest queued expectation
  always @(negedge clk) begin
    exp_t e;
    if (q.size() != 0 && q[0].at < cyc) begin
      e = q.pop_front();
      total++; bad++;
      $display("FAIL missed_pulse: got no pulse, expected one at cycle %0d", e.at);
    end
    if (bus.upd_stb || bus.err_stb) begin
      if (q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_pulse: got upd=%0b err=%0b at cycle %0d, expected none",
                 bus.upd_stb, bus.err_stb, cyc);
      end else begin
        e = q.pop_front();
        check("pulse_cycle", cyc, e.at);
        check("pulse_kind", {bus.upd_stb, bus.err_stb}, {~e.err, e.err});
        check("pulse_idx", bus.upd_idx, e.idx);
        check("pulse_hex", bus.hex_out, e.hex);
        check("pulse_dp", bus.dp_out, e.dp);
        check("pulse_valid", bus.valid, e.valid);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    bus.an_n  = 4'hF;
    bus.seg_n = 8'hFF;
    repeat (3) @(negedge clk);
    check("rst_hex", bus.hex_out, 16'h0000);
    check("rst_dp", bus.dp_out, 4'h0);
    check("rst_valid", bus.valid, 4'h0);
    check("rst_upd", bus.upd_stb, 1'b0);
    check("rst_err", bus.err_stb, 1'b0);
    check("rst_idx", bus.upd_idx, 2'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    apply(4'hE, 8'hA4, 10);
    check_state("digit0");
    check("digit0_idx", bus.upd_idx, 2'd0);

    apply(4'hB, 8'h12, 8);
    check_state("digit2");

    for (int k = 0; k < 4; k++) begin
      apply(4'hE, 8'hB0, 3);
      apply(4'hE, 8'hA4, 3);
    end
    check_state("toggle");

    apply(4'hD, 8'hFE, 8);
    check_state("illegal");
    apply(4'hC, 8'hA4, 8);
    check_state("twolow");

    apply(4'hE, 8'hF9, 8);
    apply(4'hD, 8'hA4, 8);
    apply(4'hB, 8'hB0, 8);
    apply(4'h7, 8'h99, 8);
    check("scan_hex", bus.hex_out, 16'h4321);
    check_state("scan");

    // Reset arrives while a fresh pattern is still qualifying
    bus.an_n  = 4'hE;
    bus.seg_n = 8'h24;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    check("midrst_hex", bus.hex_out, 16'h0000);
    check("midrst_valid", bus.valid, 4'h0);
    check("midrst_pulses", {bus.upd_stb, bus.err_stb}, 2'b00);
    bus.an_n  = 4'hF;
    bus.seg_n = 8'hFF;
    model_reset();
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check_state("postrst");

    for (int n = 0; n < 60; n++) begin
      logic [3:0] an;
      logic [7:0] seg;
      int         r;
      do begin
        r = int'($urandom_range(0, 9));
        if (r < 7)      an = ~(4'b0001 << $urandom_range(0, 3));
        else if (r < 8) an = 4'hF;
        else            an = 4'($urandom);
        r = int'($urandom_range(0, 19));
        if (r < 12)      seg = {1'($urandom), enc[$urandom_range(0, 15)]};
        else if (r < 15) seg = {1'($urandom), 7'h7F};
        else             seg = 8'($urandom);
      end while ({an, seg} == prev_pat);
      apply(an, seg, int'($urandom_range(2, 9)));
    end
    apply(4'hF, 8'hFF, 12);
    check_state("random");

`ifdef SEG_DEC_TIMEOUT_EN
    apply(4'hE, 8'hC0, 8);
    check("to_valid_set", bus.valid[0], 1'b1);
    apply(4'hF, 8'hFF, TIMEOUT + 6);
    check("to_valid0", bus.valid[0], 1'b0);
    check_state("timeout");
`endif

    repeat (20) @(negedge clk);
    check("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
